// File: rtl/cp0_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared CP0 types, register numbers, vectors and bit positions
//               for the MIPS32 coprocessor-0 register file.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    // Per-instruction CP0 operation produced by the exception handler
    typedef enum logic [3:0] {
        CP0_NONE    = 4'd0,
        CP0_EXC     = 4'd1,
        CP0_BADVA   = 4'd2,
        CP0_TLB_EXC = 4'd3,
        CP0_ERET    = 4'd4,
        CP0_MTC0    = 4'd5,
        CP0_TLBW    = 4'd6,
        CP0_TLBR    = 4'd7,
        CP0_TLBP    = 4'd8
    } cp0_op_t;

    // Exception details accompanying an exception commit
    typedef struct packed {
        logic [31:0] epc;
        logic        cause_bd;
        logic [4:0]  cause_exccode;
        logic [31:0] badvaddr;
    } exc_info_t;

    // Exception codes written into Cause.ExcCode
    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    // CP0 register numbers
    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Exception vectors (BEV=1 bootstrap space)
    localparam logic [31:0] EXC_VEC_REFILL  = 32'hBFC0_0200;
    localparam logic [31:0] EXC_VEC_GENERAL = 32'hBFC0_0380;

    // Status / Cause bit positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_BEV    = 22;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_EXC_HI  = 6;
    localparam int CAUSE_IP_LO   = 10;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    // Reset value and software-writable masks
    localparam logic [31:0] STATUS_RESET   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK    = 32'h0000_0300;
    localparam logic [31:0] ENTRYHI_WMASK  = 32'hFFFF_E0FF;
    localparam logic [31:0] ENTRYHI_VPN2   = 32'hFFFF_E000;
    localparam logic [31:0] ENTRYLO_WMASK  = 32'h03FF_FFFF;

endpackage : cpu_defs
`default_nettype wire

// File: rtl/cp0_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regfile_if
// Description : Bundle of pipeline <-> CP0 signals. The master side is the
//               pipeline/exception handler, the slave side is the register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_regfile_if;
    import cpu_defs::*;

    cp0_op_t     cp0_op;
    logic        is_valid_exc;
    exc_info_t   exc_info;
    logic        tlb_refill;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_rdata;
    logic [5:0]  hw_int;
    logic [31:0] tlbr_entryhi;
    logic [31:0] tlbr_entrylo0;
    logic [31:0] tlbr_entrylo1;
    logic [31:0] tlbp_index;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_entryhi;
    logic [31:0] cp0_entrylo0;
    logic [31:0] cp0_entrylo1;
    logic [31:0] cp0_index;
    logic        exc_redirect;
    logic [31:0] redirect_pc;

    modport master (
        output cp0_op, is_valid_exc, exc_info, tlb_refill,
        output mtc0_addr, mtc0_wdata, mfc0_addr, hw_int,
        output tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1, tlbp_index,
        input  mfc0_rdata, cp0_status, cp0_cause, cp0_epc,
        input  cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
        input  exc_redirect, redirect_pc
    );

    modport slave (
        input  cp0_op, is_valid_exc, exc_info, tlb_refill,
        input  mtc0_addr, mtc0_wdata, mfc0_addr, hw_int,
        input  tlbr_entryhi, tlbr_entrylo0, tlbr_entrylo1, tlbp_index,
        output mfc0_rdata, cp0_status, cp0_cause, cp0_epc,
        output cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index,
        output exc_redirect, redirect_pc
    );

endinterface : cp0_regfile_if
`default_nettype wire

// File: rtl/cp0_regfile_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : Count/Compare timer. Count advances every second cycle; TI is
//               set when Count matches Compare and cleared by a Compare write.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        count_we,
    input  wire logic [31:0] count_wdata,
    input  wire logic        compare_we,
    input  wire logic [31:0] compare_wdata,
    output logic      [31:0] count,
    output logic      [31:0] compare,
    output logic             ti
);

    logic        r_tick;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic [31:0] w_count_next;
    logic [31:0] w_compare_next;
    logic        w_ti_next;

    // Next-state: software writes win over the increment and over a TI set
    always_comb begin
        w_count_next   = r_count;
        w_compare_next = r_compare;
        w_ti_next      = r_ti;
        if (count_we) begin
            w_count_next = count_wdata;
        end else if (r_tick) begin
            w_count_next = r_count + 32'd1;
        end
        if (compare_we) begin
            w_compare_next = compare_wdata;
        end
        if (compare_we) begin
            w_ti_next = 1'b0;
        end else if (w_count_next == w_compare_next) begin
            w_ti_next = 1'b1;
        end
    end

    // Timer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            r_tick    <= ~r_tick;
            r_count   <= w_count_next;
            r_compare <= w_compare_next;
            r_ti      <= w_ti_next;
        end
    end

    assign count   = r_count;
    assign compare = r_compare;
    assign ti      = r_ti;

endmodule : cp0_timer
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : cp0_regfile
// Description : MIPS32 coprocessor-0 register file. Commits exception state,
//               executes MTC0/ERET/TLBR/TLBP side effects, hosts the timer and
//               drives the fetch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_regfile
    import cpu_defs::*;
#(
    parameter int TLB_ENTRIES = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cp0_regfile_if.slave bus
);

    localparam int          IDX_W      = $clog2(TLB_ENTRIES);
    localparam logic [31:0] c_idx_mask = {{(32 - IDX_W){1'b0}}, {IDX_W{1'b1}}};
    localparam logic [31:0] c_tlbp_mask = c_idx_mask | 32'h8000_0000;

    logic [31:0] r_index;
    logic [31:0] r_entrylo0;
    logic [31:0] r_entrylo1;
    logic [31:0] r_badvaddr;
    logic [31:0] r_entryhi;
    logic [31:0] r_status;
    logic [31:0] r_cause;
    logic [31:0] r_epc;

    logic        w_is_exc;
    logic        w_count_we;
    logic        w_compare_we;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [31:0] w_cause;

    assign w_is_exc = bus.is_valid_exc &&
                      (bus.cp0_op == CP0_EXC || bus.cp0_op == CP0_BADVA ||
                       bus.cp0_op == CP0_TLB_EXC);
    assign w_count_we   = (bus.cp0_op == CP0_MTC0) && (bus.mtc0_addr == CP0_COUNT);
    assign w_compare_we = (bus.cp0_op == CP0_MTC0) && (bus.mtc0_addr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk           (clk),
        .rst           (rst),
        .count_we      (w_count_we),
        .count_wdata   (bus.mtc0_wdata),
        .compare_we    (w_compare_we),
        .compare_wdata (bus.mtc0_wdata),
        .count         (w_count),
        .compare       (w_compare),
        .ti            (w_ti)
    );

    // The TI bit lives in the timer; splice it into the visible Cause value
    assign w_cause = (r_cause & ~(32'd1 << CAUSE_TI)) | ({31'd0, w_ti} << CAUSE_TI);

    // Architectural register updates for exceptions, ERET, MTC0 and TLB ops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index    <= 32'd0;
            r_entrylo0 <= 32'd0;
            r_entrylo1 <= 32'd0;
            r_badvaddr <= 32'd0;
            r_entryhi  <= 32'd0;
            r_status   <= STATUS_RESET;
            r_cause    <= 32'd0;
            r_epc      <= 32'd0;
        end else begin
            // Interrupt-pending lines are resampled every cycle, independent of the op
            r_cause[CAUSE_IP_HI:CAUSE_IP_LO] <= {bus.hw_int[5] | w_ti, bus.hw_int[4:0]};

            case (bus.cp0_op)
                CP0_EXC, CP0_BADVA, CP0_TLB_EXC: begin
                    if (bus.is_valid_exc) begin
                        r_epc                              <= bus.exc_info.epc;
                        r_cause[CAUSE_BD]                  <= bus.exc_info.cause_bd;
                        r_cause[CAUSE_EXC_HI:CAUSE_EXC_LO] <= bus.exc_info.cause_exccode;
                        r_status[STATUS_EXL]               <= 1'b1;
                        if (bus.cp0_op != CP0_EXC) begin
                            r_badvaddr <= bus.exc_info.badvaddr;
                        end
                        if (bus.cp0_op == CP0_TLB_EXC) begin
                            // VPN2 follows the faulting address, ASID is preserved
                            r_entryhi <= (r_entryhi & ~ENTRYHI_VPN2) |
                                         (bus.exc_info.badvaddr & ENTRYHI_VPN2);
                        end
                    end
                end
                CP0_ERET: begin
                    r_status[STATUS_EXL] <= 1'b0;
                end
                CP0_MTC0: begin
                    case (bus.mtc0_addr)
                        CP0_INDEX:    r_index    <= bus.mtc0_wdata & c_idx_mask;
                        CP0_ENTRYLO0: r_entrylo0 <= bus.mtc0_wdata & ENTRYLO_WMASK;
                        CP0_ENTRYLO1: r_entrylo1 <= bus.mtc0_wdata & ENTRYLO_WMASK;
                        CP0_ENTRYHI:  r_entryhi  <= bus.mtc0_wdata & ENTRYHI_WMASK;
                        CP0_STATUS:   r_status   <= (r_status & ~STATUS_WMASK) |
                                                    (bus.mtc0_wdata & STATUS_WMASK);
                        CP0_CAUSE:    r_cause[9:8] <= bus.mtc0_wdata[9:8];
                        CP0_EPC:      r_epc      <= bus.mtc0_wdata;
                        default: ;
                    endcase
                end
                CP0_TLBR: begin
                    r_entryhi  <= bus.tlbr_entryhi  & ENTRYHI_WMASK;
                    r_entrylo0 <= bus.tlbr_entrylo0 & ENTRYLO_WMASK;
                    r_entrylo1 <= bus.tlbr_entrylo1 & ENTRYLO_WMASK;
                end
                CP0_TLBP: begin
                    r_index <= bus.tlbp_index & c_tlbp_mask;
                end
                default: ;
            endcase
        end
    end

    // MFC0 read mux on pre-edge values; unimplemented numbers read as zero
    always_comb begin
        bus.mfc0_rdata = 32'd0;
        case (bus.mfc0_addr)
            CP0_INDEX:    bus.mfc0_rdata = r_index;
            CP0_ENTRYLO0: bus.mfc0_rdata = r_entrylo0;
            CP0_ENTRYLO1: bus.mfc0_rdata = r_entrylo1;
            CP0_BADVADDR: bus.mfc0_rdata = r_badvaddr;
            CP0_COUNT:    bus.mfc0_rdata = w_count;
            CP0_ENTRYHI:  bus.mfc0_rdata = r_entryhi;
            CP0_COMPARE:  bus.mfc0_rdata = w_compare;
            CP0_STATUS:   bus.mfc0_rdata = r_status;
            CP0_CAUSE:    bus.mfc0_rdata = w_cause;
            CP0_EPC:      bus.mfc0_rdata = r_epc;
            default:      bus.mfc0_rdata = 32'd0;
        endcase
    end

    // Redirect target: ERET returns to EPC, a first-level refill uses the refill vector
    always_comb begin
        bus.exc_redirect = 1'b0;
        bus.redirect_pc  = EXC_VEC_GENERAL;
        if (!rst) begin
            bus.exc_redirect = w_is_exc || (bus.cp0_op == CP0_ERET);
        end
        if (bus.cp0_op == CP0_ERET) begin
            bus.redirect_pc = r_epc;
        end else if (bus.cp0_op == CP0_TLB_EXC && bus.tlb_refill &&
                     !r_status[STATUS_EXL]) begin
            bus.redirect_pc = EXC_VEC_REFILL;
        end
    end

    assign bus.cp0_status   = r_status;
    assign bus.cp0_cause    = w_cause;
    assign bus.cp0_epc      = r_epc;
    assign bus.cp0_entryhi  = r_entryhi;
    assign bus.cp0_entrylo0 = r_entrylo0;
    assign bus.cp0_entrylo1 = r_entrylo1;
    assign bus.cp0_index    = r_index;

endmodule : cp0_regfile
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_regfile
// Description : Directed self-checking bench for cp0_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_regfile;
    import cpu_defs::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    cp0_regfile_if bus ();

    cp0_regfile #(.TLB_ENTRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cp0_op       = CP0_NONE;
        bus.is_valid_exc = 1'b0;
        bus.tlb_refill   = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.cp0_op     = CP0_MTC0;
        bus.mtc0_addr  = addr;
        bus.mtc0_wdata = data;
        step();
        idle();
    endtask

    task automatic mfc0_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.mfc0_addr = addr;
        #1;
        check(tag, bus.mfc0_rdata, exp);
    endtask

    initial begin
        bit seen;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle();
        bus.exc_info      = '0;
        bus.mtc0_addr     = 5'd0;
        bus.mtc0_wdata    = 32'd0;
        bus.mfc0_addr     = 5'd0;
        bus.hw_int        = 6'd0;
        bus.tlbr_entryhi  = 32'd0;
        bus.tlbr_entrylo0 = 32'd0;
        bus.tlbr_entrylo1 = 32'd0;
        bus.tlbp_index    = 32'd0;

        // Reset state
        step(); step(); step();
        check("rst_status", bus.cp0_status, 32'h0040_0000);
        check("rst_cause", bus.cp0_cause, 32'd0);
        check("rst_epc", bus.cp0_epc, 32'd0);
        check("rst_redirect", {31'd0, bus.exc_redirect}, 32'd0);
        mfc0_check("rst_count", CP0_COUNT, 32'd0);
        rst = 1'b0;

        // Park Compare far away so TI and IP7 stay clear
        mtc0(CP0_COMPARE, 32'hFFFF_FFFF);
        step(); step();
        check("quiet_cause", bus.cp0_cause, 32'd0);

        // Address error with BadVAddr
        bus.cp0_op       = CP0_BADVA;
        bus.is_valid_exc = 1'b1;
        bus.exc_info     = '{epc: 32'hBFC0_1234, cause_bd: 1'b1,
                             cause_exccode: EXCCODE_ADEL, badvaddr: 32'h0000_0003};
        #1;
        check("adel_redirect", {31'd0, bus.exc_redirect}, 32'd1);
        check("adel_pc", bus.redirect_pc, 32'hBFC0_0380);
        step();
        idle();
        check("adel_epc", bus.cp0_epc, 32'hBFC0_1234);
        check("adel_cause", bus.cp0_cause, 32'h8000_0010);
        check("adel_status", bus.cp0_status, 32'h0040_0002);
        mfc0_check("adel_badva", CP0_BADVADDR, 32'h0000_0003);

        // ERET back to a software-written EPC
        mtc0(CP0_EPC, 32'h8000_0400);
        bus.cp0_op = CP0_ERET;
        #1;
        check("eret_redirect", {31'd0, bus.exc_redirect}, 32'd1);
        check("eret_pc", bus.redirect_pc, 32'h8000_0400);
        step();
        idle();
        check("eret_status", bus.cp0_status, 32'h0040_0000);

        // TLB refill with EXL=0
        bus.cp0_op       = CP0_TLB_EXC;
        bus.is_valid_exc = 1'b1;
        bus.tlb_refill   = 1'b1;
        bus.exc_info     = '{epc: 32'h8000_1000, cause_bd: 1'b0,
                             cause_exccode: EXCCODE_TLBL, badvaddr: 32'h1234_5678};
        #1;
        check("refill_pc", bus.redirect_pc, 32'hBFC0_0200);
        step();
        idle();
        check("refill_vpn2", {13'd0, bus.cp0_entryhi[31:13]}, 32'h0000_91A2);
        check("refill_entryhi", bus.cp0_entryhi, 32'h1234_4000);
        check("refill_cause", bus.cp0_cause, 32'h0000_0008);
        check("refill_epc", bus.cp0_epc, 32'h8000_1000);

        // Same refill with EXL already set goes to the general vector
        bus.cp0_op       = CP0_TLB_EXC;
        bus.is_valid_exc = 1'b1;
        bus.tlb_refill   = 1'b1;
        #1;
        check("refill_exl_pc", bus.redirect_pc, 32'hBFC0_0380);
        step();
        idle();

        // MTC0 write masks
        mtc0(CP0_STATUS, 32'hFFFF_FFFF);
        check("mask_status", bus.cp0_status, 32'h0040_FF03);
        mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
        check("mask_cause", bus.cp0_cause, 32'h0000_0308);
        mtc0(CP0_ENTRYHI, 32'hFFFF_FFFF);
        check("mask_entryhi", bus.cp0_entryhi, 32'hFFFF_E0FF);
        mtc0(CP0_ENTRYLO0, 32'hFFFF_FFFF);
        check("mask_entrylo0", bus.cp0_entrylo0, 32'h03FF_FFFF);
        mtc0(CP0_INDEX, 32'hFFFF_FFFF);
        check("mask_index", bus.cp0_index, 32'h0000_000F);
        mtc0(CP0_BADVADDR, 32'hFFFF_FFFF);
        mfc0_check("badva_ro", CP0_BADVADDR, 32'h1234_5678);
        mfc0_check("unmapped", 5'd5, 32'd0);

        // Hardware interrupt sampling into Cause.IP
        bus.hw_int = 6'b000101;
        step();
        check("hwint_cause", bus.cp0_cause, 32'h0000_1708);
        bus.hw_int = 6'd0;
        step();
        check("hwint_clear", bus.cp0_cause, 32'h0000_0308);

        // TLBP and TLBR
        bus.cp0_op     = CP0_TLBP;
        bus.tlbp_index = 32'h8000_0007;
        step();
        idle();
        check("tlbp_miss", bus.cp0_index, 32'h8000_0007);
        bus.cp0_op     = CP0_TLBP;
        bus.tlbp_index = 32'h7FFF_FFF3;
        step();
        idle();
        check("tlbp_hit", bus.cp0_index, 32'h0000_0003);
        bus.cp0_op        = CP0_TLBR;
        bus.tlbr_entryhi  = 32'hAAAA_AAAA;
        bus.tlbr_entrylo0 = 32'hFFFF_FFFF;
        bus.tlbr_entrylo1 = 32'h1234_5678;
        step();
        idle();
        check("tlbr_entryhi", bus.cp0_entryhi, 32'hAAAA_A0AA);
        check("tlbr_entrylo0", bus.cp0_entrylo0, 32'h03FF_FFFF);
        check("tlbr_entrylo1", bus.cp0_entrylo1, 32'h0234_5678);
        bus.cp0_op = CP0_TLBW;
        step();
        idle();
        check("tlbw_entryhi", bus.cp0_entryhi, 32'hAAAA_A0AA);

        // Timer interrupt
        mtc0(CP0_COUNT, 32'd0);
        mtc0(CP0_COMPARE, 32'd3);
        check("ti_cleared", {31'd0, bus.cp0_cause[30]}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.cp0_cause[30];
        end
        check("ti_set", {31'd0, seen}, 32'd1);
        mfc0_check("ti_count", CP0_COUNT, 32'd3);
        step();
        check("ti_ip7", {31'd0, bus.cp0_cause[15]}, 32'd1);
        mtc0(CP0_COMPARE, 32'd100);
        check("ti_clear", {31'd0, bus.cp0_cause[30]}, 32'd0);

        // Reset in the middle of an MTC0 wins
        rst            = 1'b1;
        bus.cp0_op     = CP0_MTC0;
        bus.mtc0_addr  = CP0_STATUS;
        bus.mtc0_wdata = 32'h0000_0001;
        step();
        idle();
        check("rst2_status", bus.cp0_status, 32'h0040_0000);
        check("rst2_epc", bus.cp0_epc, 32'd0);
        check("rst2_entryhi", bus.cp0_entryhi, 32'd0);
        check("rst2_cause", bus.cp0_cause, 32'd0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cp0_regfile
`default_nettype wire
